// File: rtl/memb_pkg.sv
// Shared types and width helpers for the operand-B skew buffer.
package memb_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // t spans 0 .. count+DIM-1, count spans 0 .. DEPTH
    function automatic int t_width(input int depth, input int dim);
        return $clog2(depth + dim);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memb_skew_buf_if.sv
// Load/stream handshake and skewed output bus of the operand-B buffer.
interface memb_skew_buf_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int DEPTH   = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                               clr;
    logic                               wr_en;
    logic signed [DIM-1:0][BITS_AB-1:0] Bin;
    logic                               start;
    logic                               replay;
    logic signed [DIM-1:0][BITS_AB-1:0] Bout;
    logic [DIM-1:0]                     col_valid;
    logic                               busy;
    logic                               full;
    logic [CW-1:0]                      count;
    logic                               done;

    modport master (
        output clr, wr_en, Bin, start, replay,
        input  Bout, col_valid, busy, full, count, done
    );

    modport slave (
        input  clr, wr_en, Bin, start, replay,
        output Bout, col_valid, busy, full, count, done
    );

endinterface

// File: rtl/memb_skew_col.sv
// One lane of the skew buffer: row storage plus a registered read delayed by COL cycles.
module memb_skew_col
    import memb_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DEPTH   = 8,
    parameter int DIM     = 8,
    parameter int COL     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [idx_width(DEPTH)-1:0]            wr_idx,
    input  logic [BITS_AB-1:0]                     wr_data,
    input  logic                                   run,
    input  logic [t_width(DEPTH, DIM)-1:0]         t,
    input  logic [$clog2(DEPTH+1)-1:0]             count,
    output logic [BITS_AB-1:0]                     dout,
    output logic                                   valid
);
    localparam int TW = t_width(DEPTH, DIM);
    localparam int IW = idx_width(DEPTH);

    logic [BITS_AB-1:0] mem [DEPTH];
    logic [TW:0]        diff;
    logic               in_range;
    logic [BITS_AB-1:0] dout_q, dout_d;
    logic               valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Extra MSB acts as the borrow of t-COL, so "t < COL" needs no separate compare
    always_comb begin
        diff     = {1'b0, t} - {1'b0, TW'(COL)};
        in_range = run && !diff[TW] && (diff[TW-1:0] < TW'(count));
        dout_d   = '0;
        valid_d  = 1'b0;
        if (in_range) begin
            dout_d  = mem[diff[IW-1:0]];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;

endmodule

// File: rtl/memb_skew_buf.sv
// Operand-B staging buffer: loads rows, then streams them diagonally skewed across DIM lanes.
module memb_skew_buf
    import memb_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    memb_skew_buf_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = t_width(DEPTH, DIM);
    localparam int IW = idx_width(DEPTH);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] t_q, t_d;
    logic          replay_q, replay_d;
    logic          done_q, done_d;
    logic          wr_accept;
    logic          full;
    logic          busy;
    logic          run;
    logic [TW-1:0] t_end;
    logic [TW-1:0] t_done;

    logic [DIM-1:0][BITS_AB-1:0] bout_w;
    logic [DIM-1:0]              valid_w;

    // Lanes present t during 0..count+DIM-2 one edge later; t_end is the idle edge back to LOAD
    assign t_end  = TW'(count_q) + TW'(DIM - 1);
    assign t_done = t_end - TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            count_q  <= '0;
            t_q      <= '0;
            replay_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            t_q      <= t_d;
            replay_q <= replay_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        t_d       = t_q;
        replay_d  = replay_q;
        done_d    = 1'b0;
        wr_accept = 1'b0;
        if (bus.clr) begin
            state_d = LOAD;
            count_d = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.wr_en && !full) begin
                        wr_accept = 1'b1;
                        count_d   = count_q + CW'(1);
                    end
                    // A same-edge write counts toward the stream length
                    if (bus.start && (count_d != '0)) begin
                        state_d  = STREAM;
                        t_d      = '0;
                        replay_d = bus.replay;
                    end
                end
                STREAM: begin
                    t_d = t_q + TW'(1);
                    if (t_q == t_done) begin
                        done_d = 1'b1;
                    end
                    if (t_q == t_end) begin
                        state_d = LOAD;
                        t_d     = '0;
                        if (!replay_q) begin
                            count_d = '0;
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == STREAM);
        full = (count_q == CW'(DEPTH));
        run  = busy && !bus.clr;
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_col
        memb_skew_col #(
            .BITS_AB (BITS_AB),
            .DEPTH   (DEPTH),
            .DIM     (DIM),
            .COL     (gi)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_accept),
            .wr_idx  (count_q[IW-1:0]),
            .wr_data (bus.Bin[gi]),
            .run     (run),
            .t       (t_q),
            .count   (count_q),
            .dout    (bout_w[gi]),
            .valid   (valid_w[gi])
        );
    end

    assign bus.Bout      = bout_w;
    assign bus.col_valid = valid_w;
    assign bus.busy      = busy;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.done      = done_q;

endmodule

// File: doc/memb_skew_buf.md
# memb_skew_buf

Operand-B staging buffer for the systolic MAC array, successor to the fixed per-column FIFO bank. Loads up to DEPTH rows of B, one full row per cycle. On command it streams them into the array with diagonal skew: column i lags column 0 by i cycles, with zero padding and per-column valid bits. Optional replay keeps the loaded tile for weight-stationary reuse without reloading.

## Interface
- BITS_AB, 8, signed element width
- DIM, 8, array columns (lanes)
- DEPTH, 8, max rows held (≥1)
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- clr  in  1  synchronous clear: abort stream, count→0
- wr_en  in  1  write Bin as next row (LOAD state only)
- Bin  in  DIM×BITS_AB signed  row to write; Bin[c] is column c
- start  in  1  begin streaming (LOAD state, count>0 only)
- replay  in  1  sampled with start: 1 = keep rows after stream
- Bout  out  DIM×BITS_AB signed  skewed output, registered
- col_valid  out  DIM  col_valid[c] = Bout[c] carries real data
- busy  out  1  state is STREAM
- full  out  1  count==DEPTH
- count  out  $clog2(DEPTH+1)  rows loaded
- done  out  1  one-cycle pulse with last valid output

## Operation
- States: LOAD, STREAM. Reset/clr → LOAD.
- LOAD: wr_en && !full → row stored at index count, count+1. wr_en while full → dropped, no state change. start && count>0 → STREAM, t=0, latch replay. start with count==0 → ignored. wr_en and start on the same edge: the write lands, and the stream uses the new count.
- STREAM: t runs 0 … count+DIM−2 (count+DIM−1 cycles). For each column c, with r=t−c:
  - 0≤r<count: Bout[c]=row r col c, col_valid[c]=1.
  - Otherwise: Bout[c]=0, col_valid[c]=0.
- Last cycle (t=count+DIM−2): done=1. Next edge → LOAD. If latched replay=0, count→0. If replay=1, count and data are kept.
- In STREAM, wr_en and start are ignored. clr has priority over everything: at the next edge, state→LOAD, count→0, Bout/col_valid→0, done→0.
- Storage contents are undefined after clear. Only count defines validity.

## Timing
- Reset values: Bout=0, col_valid=0, busy=0, full=0, count=0, done=0, state LOAD. rst clears immediately, with no clock needed.
- start sampled at edge E0. busy=1 after E0. The t=0 outputs are driven after edge E1. Latency from start to first Bout[0] is 2 edges.
- busy deasserts on the edge after the last output edge, in the same cycle Bout/col_valid return to 0.
- full and count update on the write edge. full is combinational from count.
- A back-to-back start is accepted in the first LOAD cycle after done (replay=1 case).

## Structure
- Package memb_pkg:
  - state enum {LOAD, STREAM}.
  - Width helper for count and t: $clog2(DEPTH+DIM).
- Sub-module memb_skew_col, one instance per column, with parameter COL:
  - DEPTH×BITS_AB storage, written at the shared write index.
  - Read index t−COL, range check against count.
  - Output register and valid register.
- Top level holds the FSM, count, t and done.

## Test plan
DIM=4, DEPTH=4, BITS_AB=8, row r col c value = 16r+c.
- Reset: assert rst mid-cycle without a clock → all outputs 0 immediately; count=0, full=0.
- Full stream: write rows 0–3 (full=1), start, replay=0.
  - Bout[0] valid for t=0..3 with values 0,16,32,48, then 0.
  - Bout[3] valid for t=3..6 with values 3,19,35,51.
  - done at t=6; count=0 afterwards.
- Partial: write 2 rows, start.
  - Stream is 5 cycles.
  - Bout[1] valid at t=1,2 with values 1,17.
  - col_valid[3] high only at t=3,4.
- Overflow: 5 writes with the fifth Bin=0x7F → count=4, full=1; streamed data contains no 0x7F.
- Replay: load 4 rows, start with replay=1, then start again after done → identical 7-cycle sequences; count stays 4 throughout.
- Abort: clr at t=2 → next edge Bout=0, col_valid=0, busy=0, count=0, no done. Repeat with rst at t=2 → same result, applied asynchronously.
